usb_pe_tx_arbiter: RTL
======================

# usb_pe_tx_arbiter

Packet-atomic arbiter that shares the single SIE transmit interface among several protocol-engine transmit sources (handshake generator, endpoint data sources). It sits between the PE transaction state machines and the SIE transmit port in the clk48 domain. It grants one requester per packet and holds the grant until that packet's last byte is accepted. It enforces a programmable inter-packet gap and never starts a packet while the SIE is receiving.

## Interface
- REQUESTERS, 2: number of transmit sources, ≥2
- IPG_CYCLES, 4: idle clk48 cycles enforced after each packet, 0..255

- clk48  in  1  system clock, 48 MHz
- rst  in  1  reset, asynchronous, active-high
- reqSendPacket  in  REQUESTERS  per-source packet request, level
- reqDataValid  in  REQUESTERS  per-source byte valid
- reqIsLastByte  in  REQUESTERS  per-source last-byte flag
- reqData  in  8*REQUESTERS  per-source byte, source i at [8i+7:8i]
- reqGrant  out  REQUESTERS  one-hot grant, registered
- reqAcceptNewData  out  REQUESTERS  per-source byte accept
- rxBusy  in  1  SIE is receiving; blocks new grants
- txReqSendPacket  out  1  to SIE
- txDataValid  out  1  to SIE
- txIsLastByte  out  1  to SIE
- txData  out  8  to SIE
- txAcceptNewData  in  1  from SIE
- packetDone  out  1  one-cycle pulse when a packet's last byte is accepted

## Operation
- States: ARB_IDLE, ARB_SEND, ARB_GAP.
- ARB_IDLE: if !rxBusy and any reqSendPacket bit is set, pick a winner, register reqGrant, and go to ARB_SEND. Otherwise stay.
- Winner selection is round-robin. Search starts at index (lastWinner+1) mod REQUESTERS. The rr pointer resets to 0, so source 0 has first priority after reset.
- ARB_SEND:
  - txReqSendPacket=1.
  - txDataValid, txIsLastByte and txData mux combinationally from the granted source.
  - reqAcceptNewData[g]=txAcceptNewData. All other reqAcceptNewData bits are 0.
- Byte transfer happens when txDataValid && txAcceptNewData. If that byte also has txIsLastByte set:
  - pulse packetDone;
  - set lastWinner to g and clear reqGrant;
  - go to ARB_GAP with gapCnt=IPG_CYCLES, or to ARB_IDLE if IPG_CYCLES==0.
- ARB_GAP: decrement gapCnt every cycle and go to ARB_IDLE when it reaches 1. rxBusy and requests are ignored in this state.
- A granted source deasserting reqSendPacket mid-packet is a protocol error. The grant is held regardless; only the last byte ends the packet.
- rxBusy rising during ARB_SEND is ignored, because the packet is already committed.
- Outside ARB_SEND, all tx* outputs and reqAcceptNewData are 0.

## Timing
- Reset values: reqGrant=0, reqAcceptNewData=0, txReqSendPacket=0, txDataValid=0, txIsLastByte=0, txData=0, packetDone=0, state=ARB_IDLE, gapCnt=0, rr pointer=0.
- Grant latency: a request seen in ARB_IDLE at cycle N gives reqGrant and txReqSendPacket at N+1.
- Datapath is combinational from source to SIE: zero cycles for data, zero cycles for accept.
- packetDone is registered and asserts the cycle after the last byte is accepted.
- Back-to-back packets: the next grant comes no earlier than IPG_CYCLES+1 cycles after the last-byte accept (IPG_CYCLES=0 gives 1 cycle).
- rst asserted mid-packet: all outputs clear immediately and asynchronously, and the SIE request is dropped. The packet is aborted with no packetDone.

## Configuration
- USB_TX_ARB_FIXED_PRIO0_EN defined: source 0 (handshake generator) wins whenever it requests in ARB_IDLE. Sources 1..REQUESTERS-1 round-robin among themselves, and source 0 wins do not advance their pointer.
- Undefined: pure round-robin over all sources.

## Structure
- TxArbState enum (ARB_IDLE, ARB_SEND, ARB_GAP) goes in sie_defs_pkg, beside the other SIE/PE interface definitions.
- Sub-module usb_rr_picker: combinational picker taking a request vector and a start index and returning a one-hot winner. It is reused for the fixed-priority variant's 1..N-1 subset.

## Test plan
- Single request: source 1 sends 3 bytes 0xC3,0x11,0x22 with the last flag on 0x22.
  - Required: reqGrant=2'b10 one cycle after the request; SIE sees the bytes in order; packetDone pulses once; next grant no earlier than 5 cycles after the last accept (IPG_CYCLES=4).
- Contention: sources 0 and 1 request continuously, 2-byte packets, macro undefined.
  - Required: grants alternate 0,1,0,1; no byte interleaving.
- Macro defined, REQUESTERS=3, all three requesting.
  - Required: source 0 wins every arbitration; when source 0 goes idle, sources 1 and 2 alternate.
- rxBusy held high while source 0 requests.
  - Required: no grant while rxBusy is high; grant 1 cycle after rxBusy falls.
- SIE stalls with txAcceptNewData=0 for 10 cycles mid-packet.
  - Required: data held stable, reqAcceptNewData=0, grant kept.
- rst pulsed after byte 2 of a 4-byte packet.
  - Required: all outputs 0 within the reset cycle; no packetDone; after release, the rr pointer is 0 and source 0 has first priority.

Source files
------------

// File: rtl/sie_defs_pkg.sv
// Shared SIE / protocol-engine interface definitions.
package sie_defs_pkg;

   localparam int TX_BYTE_W = 8;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_SEND = 2'd1,
      ARB_GAP  = 2'd2
   } TxArbState;

endpackage

// File: rtl/usb_rr_picker.sv
// Combinational round-robin picker: one-hot winner, searching upward from startIdx with wrap.
module usb_rr_picker #(
   parameter  int REQUESTERS = 2,
   localparam int IDX_W      = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
   input  logic [REQUESTERS-1:0] req,
   input  logic [IDX_W-1:0]      startIdx,
   output logic [REQUESTERS-1:0] winner
);

   logic [2*REQUESTERS-1:0] reqDbl;
   logic [2*REQUESTERS-1:0] winDbl;
   logic [REQUESTERS-1:0]   reqRot;
   logic [REQUESTERS-1:0]   winRot;

   // Rotate so startIdx lands at bit 0, isolate the lowest set bit, rotate back.
   assign reqDbl = {req, req} >> startIdx;
   assign reqRot = reqDbl[REQUESTERS-1:0];
   assign winRot = reqRot & (~reqRot + REQUESTERS'(1));
   assign winDbl = {winRot, winRot} << startIdx;
   assign winner = winDbl[2*REQUESTERS-1:REQUESTERS];

endmodule

// File: rtl/usb_pe_tx_arbiter.sv
// Packet-atomic arbiter sharing the SIE transmit port among PE sources, with inter-packet gap.
// Option: USB_TX_ARB_FIXED_PRIO0_EN gives source 0 absolute priority over a 1..N-1 round-robin.
module usb_pe_tx_arbiter
   import sie_defs_pkg::*;
#(
   parameter int REQUESTERS = 2,
   parameter int IPG_CYCLES = 4
) (
   input  logic                              clk48,
   input  logic                              rst,
   input  logic [REQUESTERS-1:0]             reqSendPacket,
   input  logic [REQUESTERS-1:0]             reqDataValid,
   input  logic [REQUESTERS-1:0]             reqIsLastByte,
   input  logic [TX_BYTE_W*REQUESTERS-1:0]   reqData,
   output logic [REQUESTERS-1:0]             reqGrant,
   output logic [REQUESTERS-1:0]             reqAcceptNewData,
   input  logic                              rxBusy,
   output logic                              txReqSendPacket,
   output logic                              txDataValid,
   output logic                              txIsLastByte,
   output logic [TX_BYTE_W-1:0]              txData,
   input  logic                              txAcceptNewData,
   output logic                              packetDone
);

   localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

   TxArbState             state, stateNext;
   logic [7:0]            gapCnt, gapCntNext;
   logic [IDX_W-1:0]      rrStart, rrStartNext;
   logic [IDX_W-1:0]      grantIdx;
   logic [REQUESTERS-1:0] grantNext;
   logic                  grantAdv, grantAdvNext;
   logic                  packetDoneNext;
   logic [REQUESTERS-1:0] pickReq, pickWin, winner;
   logic                  winAdvancesRr;
   logic                  lastXfer;

   usb_rr_picker #(.REQUESTERS(REQUESTERS)) rrPicker (
      .req      (pickReq),
      .startIdx (rrStart),
      .winner   (pickWin)
   );

`ifdef USB_TX_ARB_FIXED_PRIO0_EN
   assign pickReq = reqSendPacket & ~REQUESTERS'(1);

   // Handshakes from source 0 bypass the rotation and leave the pointer untouched.
   always_comb begin
      winner        = pickWin;
      winAdvancesRr = 1'b1;
      if (reqSendPacket[0]) begin
         winner        = REQUESTERS'(1);
         winAdvancesRr = 1'b0;
      end
   end
`else
   assign pickReq       = reqSendPacket;
   assign winner        = pickWin;
   assign winAdvancesRr = 1'b1;
`endif

   always_comb begin
      grantIdx = '0;
      for (int i = 0; i < REQUESTERS; i++)
         if (reqGrant[i]) grantIdx = IDX_W'(i);
   end

   // Zero-latency mux from the granted source to the SIE and back.
   always_comb begin
      txReqSendPacket  = 1'b0;
      txDataValid      = 1'b0;
      txIsLastByte     = 1'b0;
      txData           = '0;
      reqAcceptNewData = '0;
      if (state == ARB_SEND) begin
         txReqSendPacket = 1'b1;
         for (int i = 0; i < REQUESTERS; i++) begin
            if (reqGrant[i]) begin
               txDataValid         = reqDataValid[i];
               txIsLastByte        = reqIsLastByte[i];
               txData              = reqData[TX_BYTE_W*i +: TX_BYTE_W];
               reqAcceptNewData[i] = txAcceptNewData;
            end
         end
      end
   end

   assign lastXfer = (state == ARB_SEND) && txDataValid && txAcceptNewData && txIsLastByte;

   always_comb begin
      stateNext      = state;
      gapCntNext     = gapCnt;
      rrStartNext    = rrStart;
      grantNext      = reqGrant;
      grantAdvNext   = grantAdv;
      packetDoneNext = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (!rxBusy && (|reqSendPacket)) begin
               stateNext    = ARB_SEND;
               grantNext    = winner;
               grantAdvNext = winAdvancesRr;
            end
         end
         ARB_SEND: begin
            if (lastXfer) begin
               packetDoneNext = 1'b1;
               grantNext      = '0;
               if (grantAdv)
                  rrStartNext = (grantIdx == IDX_W'(REQUESTERS-1)) ? '0 : grantIdx + 1'b1;
               if (IPG_CYCLES == 0) begin
                  stateNext = ARB_IDLE;
               end else begin
                  stateNext  = ARB_GAP;
                  gapCntNext = 8'(IPG_CYCLES);
               end
            end
         end
         ARB_GAP: begin
            gapCntNext = gapCnt - 1'b1;
            if (gapCnt <= 8'd1) stateNext = ARB_IDLE;
         end
         default: stateNext = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk48 or posedge rst) begin
      if (rst) begin
         state      <= ARB_IDLE;
         gapCnt     <= '0;
         rrStart    <= '0;
         reqGrant   <= '0;
         grantAdv   <= 1'b0;
         packetDone <= 1'b0;
      end else begin
         state      <= stateNext;
         gapCnt     <= gapCntNext;
         rrStart    <= rrStartNext;
         reqGrant   <= grantNext;
         grantAdv   <= grantAdvNext;
         packetDone <= packetDoneNext;
      end
   end

endmodule
